// File: rtl/store_serializer.sv
// Store-path narrowing: writes the low 1/2/4/8 bytes of a register
// little-endian over a byte-wide write port and flags lossy truncation.
module store_serializer #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ready,
  output logic                  done,
  output logic                  trunc,
  output logic                  busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [55:0] data_q;
  logic [2:0]  idx;
  logic [2:0]  last;
  logic        trunc_q;
  logic        trunc_nx;
  logic [2:0]  last_nx;

  assign req_ready = (state == IDLE);
  assign busy      = (state == SEND);
  assign mem_we    = (state == SEND);

  // Discarded bits must all equal the stored field's sign bit.
  always_comb begin
    trunc_nx = 1'b0;
    unique case (req_size)
      2'b00: trunc_nx = ~(&req_data[63:7] | ~|req_data[63:7]);
      2'b01: trunc_nx = ~(&req_data[63:15] | ~|req_data[63:15]);
      2'b10: trunc_nx = ~(&req_data[63:31] | ~|req_data[63:31]);
      2'b11: trunc_nx = 1'b0;
      default: trunc_nx = 1'b0;
    endcase
  end

  assign last_nx = {req_size == 2'b11, req_size[1], |req_size};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      data_q    <= '0;
      idx       <= '0;
      last      <= '0;
      trunc_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      trunc     <= 1'b0;
    end else begin
      done  <= 1'b0;
      trunc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SEND;
            mem_addr  <= req_addr;
            mem_wdata <= req_data[7:0];
            data_q    <= req_data[63:8];
            idx       <= '0;
            last      <= last_nx;
            trunc_q   <= trunc_nx;
          end
        end
        SEND: begin
          if (mem_ready) begin
            if (idx == last) begin
              state <= IDLE;
              done  <= 1'b1;
              trunc <= trunc_q;
            end else begin
              idx       <= idx + 3'd1;
              mem_addr  <= mem_addr + ADDR_WIDTH'(1);
              mem_wdata <= data_q[7:0];
              data_q    <= {8'h00, data_q[55:8]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
